cpu_phase_ctrl: RTL and testbench

CPU_PHASE_CTRL -- requirements
Module: cpu_phase_ctrl

---
 rtl/cpu_phase_ctrl.sv | 96 +++++++++
 tb/tb_cpu_phase_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/cpu_phase_ctrl.sv
// CPU clock phase generator: divides clk into a CPU clock, qualifies a bus access
// window at phase 0 and aligns synchronized interrupt requests to that window.
module cpu_phase_ctrl #(
  parameter int unsigned         DIV         = 4,
  parameter int unsigned         N_IRQ       = 1,
  parameter logic [N_IRQ-1:0]    IRQ_EDGE    = '0,
  parameter int unsigned         SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       nrst,
  input  logic                       en,
  output logic                       cpu_clk,
  output logic [$clog2(DIV)-1:0]     phase,
  output logic                       bus_win,
  input  logic                       bus_cs_in,
  output logic                       bus_cs_out,
  input  logic [N_IRQ-1:0]           irq_in,
  input  logic [N_IRQ-1:0]           irq_ack,
  output logic [N_IRQ-1:0]           irq_out,
  output logic                       cpu_irq
);

  localparam int unsigned PW = $clog2(DIV);

  logic                 run;
  logic [PW-1:0]        phase_nxt;
  logic [N_IRQ-1:0]     sync_q [SYNC_STAGES];
  logic [N_IRQ-1:0]     s;
  logic [N_IRQ-1:0]     s_prev;
  logic [N_IRQ-1:0]     s_rise;
  logic [N_IRQ-1:0]     pend;
  logic [N_IRQ-1:0]     pend_nxt;
  logic [N_IRQ-1:0]     irq_nxt;
  logic                 slot;

  always_comb begin
    phase_nxt = '0;
    if (run && (phase != PW'(DIV - 1))) begin
      phase_nxt = phase + PW'(1);
    end
  end

  // cpu_clk is registered from the next phase so it toggles cleanly on clk.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      run     <= 1'b0;
      phase   <= '0;
      cpu_clk <= 1'b0;
    end else begin
      run     <= en;
      phase   <= phase_nxt;
      cpu_clk <= (phase_nxt >= PW'(DIV / 2));
    end
  end

  assign slot       = run && (phase == '0);
  assign bus_win    = slot;
  assign bus_cs_out = bus_cs_in && bus_win;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int unsigned k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= '0;
      end
    end else begin
      sync_q[0] <= irq_in;
      for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
    end
  end

  assign s      = sync_q[SYNC_STAGES-1];
  assign s_rise = s & ~s_prev;

  // A fresh edge overrides a same-cycle ack; level channels never hold pend.
  assign pend_nxt = IRQ_EDGE & (s_rise | (pend & ~irq_ack));
  assign irq_nxt  = (~IRQ_EDGE & s) | pend_nxt;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      s_prev  <= '0;
      pend    <= '0;
      irq_out <= '0;
    end else begin
      s_prev <= s;
      pend   <= pend_nxt;
      if (slot) begin
        irq_out <= irq_nxt;
      end
    end
  end

  assign cpu_irq = |irq_out;

endmodule

// File: tb/tb_cpu_phase_ctrl.sv
// Randomized bench for cpu_phase_ctrl: two configurations run side by side against
// a cycle-level behavioural model built from input history and phase counters.
module tb_cpu_phase_ctrl;

  logic       clk;
  logic       nrst;
  logic       en;
  logic       bus_cs_in;
  logic [1:0] irq_in;
  logic [1:0] irq_ack;

  logic       a_cpu_clk, a_bus_win, a_cs_out, a_cpu_irq;
  logic [1:0] a_phase;
  logic [0:0] a_irq_out;
  logic       b_cpu_clk, b_bus_win, b_cs_out, b_cpu_irq;
  logic [2:0] b_phase;
  logic [1:0] b_irq_out;

  int checks;
  int errors;

  cpu_phase_ctrl dut_a (
    .clk(clk), .nrst(nrst), .en(en),
    .cpu_clk(a_cpu_clk), .phase(a_phase), .bus_win(a_bus_win),
    .bus_cs_in(bus_cs_in), .bus_cs_out(a_cs_out),
    .irq_in(irq_in[0:0]), .irq_ack(irq_ack[0:0]),
    .irq_out(a_irq_out), .cpu_irq(a_cpu_irq)
  );

  cpu_phase_ctrl #(.DIV(6), .N_IRQ(2), .IRQ_EDGE(2'b10), .SYNC_STAGES(3)) dut_b (
    .clk(clk), .nrst(nrst), .en(en),
    .cpu_clk(b_cpu_clk), .phase(b_phase), .bus_win(b_bus_win),
    .bus_cs_in(bus_cs_in), .bus_cs_out(b_cs_out),
    .irq_in(irq_in), .irq_ack(irq_ack),
    .irq_out(b_irq_out), .cpu_irq(b_cpu_irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model configuration and state, index 0 = dut_a, 1 = dut_b
  int       m_div  [2];
  int       m_st   [2];
  bit [1:0] m_mask [2];
  bit [1:0] m_edge [2];
  int       m_run  [2];
  int       m_phase[2];
  bit       m_clk  [2];
  bit [1:0] m_hist [2][5];
  bit [1:0] m_pend [2];
  bit [1:0] m_out  [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset(input int k);
    m_run[k] = 0;
    m_phase[k] = 0;
    m_clk[k] = 1'b0;
    m_pend[k] = '0;
    m_out[k] = '0;
    for (int j = 0; j < 5; j++) m_hist[k][j] = '0;
  endtask

  task automatic model_step(input int k, input bit en_s, input bit [1:0] irq_s, input bit [1:0] ack_s);
    bit [1:0] s_now, s_old, pend_new;
    s_now = m_hist[k][m_st[k]-1];
    s_old = m_hist[k][m_st[k]];
    pend_new = m_pend[k];
    for (int ch = 0; ch < 2; ch++) begin
      if (m_mask[k][ch] && m_edge[k][ch]) begin
        if (s_now[ch] && !s_old[ch]) pend_new[ch] = 1'b1;
        else if (ack_s[ch])          pend_new[ch] = 1'b0;
      end
    end
    if (m_run[k] != 0 && m_phase[k] == 0) begin
      for (int ch = 0; ch < 2; ch++) begin
        if (m_mask[k][ch]) m_out[k][ch] = m_edge[k][ch] ? pend_new[ch] : s_now[ch];
      end
    end
    m_pend[k] = pend_new;
    m_phase[k] = (m_run[k] != 0) ? (m_phase[k] + 1) % m_div[k] : 0;
    m_clk[k] = (m_phase[k] >= m_div[k] / 2);
    for (int j = 4; j > 0; j--) m_hist[k][j] = m_hist[k][j-1];
    m_hist[k][0] = irq_s & m_mask[k];
    m_run[k] = en_s ? 1 : 0;
  endtask

  task automatic check_all(input string tag);
    bit wa, wb;
    wa = (m_run[0] != 0) && (m_phase[0] == 0);
    wb = (m_run[1] != 0) && (m_phase[1] == 0);
    check({tag, ".a_phase"},   a_phase,   m_phase[0]);
    check({tag, ".a_cpu_clk"}, a_cpu_clk, m_clk[0]);
    check({tag, ".a_bus_win"}, a_bus_win, wa);
    check({tag, ".a_cs_out"},  a_cs_out,  wa && bus_cs_in);
    check({tag, ".a_irq_out"}, a_irq_out, m_out[0][0]);
    check({tag, ".a_cpu_irq"}, a_cpu_irq, |m_out[0]);
    check({tag, ".b_phase"},   b_phase,   m_phase[1]);
    check({tag, ".b_cpu_clk"}, b_cpu_clk, m_clk[1]);
    check({tag, ".b_bus_win"}, b_bus_win, wb);
    check({tag, ".b_cs_out"},  b_cs_out,  wb && bus_cs_in);
    check({tag, ".b_irq_out"}, b_irq_out, m_out[1]);
    check({tag, ".b_cpu_irq"}, b_cpu_irq, |m_out[1]);
  endtask

  // Inputs are driven at negedge; model advances at posedge; outputs checked at next negedge.
  task automatic run_cycle(input string tag);
    @(posedge clk);
    if (nrst) begin
      model_step(0, en, irq_in, irq_ack);
      model_step(1, en, irq_in, irq_ack);
    end else begin
      model_reset(0);
      model_reset(1);
    end
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic drive_random();
    if (en) begin
      if ($urandom_range(0, 39) == 0) en = 1'b0;
    end else begin
      if ($urandom_range(0, 7) == 0) en = 1'b1;
    end
    for (int ch = 0; ch < 2; ch++) begin
      if ($urandom_range(0, 9) == 0) irq_in[ch] = ~irq_in[ch];
      irq_ack[ch] = ($urandom_range(0, 7) == 0);
    end
    bus_cs_in = $urandom_range(0, 1) != 0;
  endtask

  task automatic async_reset(input string tag, input int hold);
    #3 nrst = 1'b0;
    model_reset(0);
    model_reset(1);
    #1 check_all(tag);
    repeat (hold) run_cycle({tag, "_hold"});
    nrst = 1'b1;
  endtask

  initial begin
    bit found;
    checks = 0;
    errors = 0;
    m_div[0] = 4;  m_st[0] = 2; m_mask[0] = 2'b01; m_edge[0] = 2'b00;
    m_div[1] = 6;  m_st[1] = 3; m_mask[1] = 2'b11; m_edge[1] = 2'b10;
    model_reset(0);
    model_reset(1);
    nrst = 1'b1; en = 1'b0; bus_cs_in = 1'b0; irq_in = '0; irq_ack = '0;

    #1 nrst = 1'b0;
    #1 check_all("por");
    repeat (3) run_cycle("por_hold");

    // Steady run with chip select held high
    en = 1'b1; bus_cs_in = 1'b1; nrst = 1'b1;
    repeat (24) run_cycle("steady");

    // Level channel: raise then drop irq_in[0]
    irq_in[0] = 1'b1;
    repeat (14) run_cycle("lvl_rise");
    irq_in[0] = 1'b0;
    repeat (14) run_cycle("lvl_fall");

    // Edge channel: pulse, hold, ack, and ack coincident with a new edge
    irq_in[1] = 1'b1; run_cycle("edge_pulse"); irq_in[1] = 1'b0;
    repeat (16) run_cycle("edge_hold");
    irq_ack[1] = 1'b1; run_cycle("edge_ack"); irq_ack[1] = 1'b0;
    repeat (8) run_cycle("edge_clr");
    irq_in[1] = 1'b1; run_cycle("edge_p2"); irq_in[1] = 1'b0;
    run_cycle("edge_p2b");
    run_cycle("edge_p2c");
    irq_ack[1] = 1'b1; run_cycle("edge_coinc"); irq_ack[1] = 1'b0;
    repeat (10) run_cycle("edge_coinc_after");

    // Run disabled for 10 clk while a pulse arrives on the edge channel
    irq_ack[1] = 1'b1; run_cycle("pre_en"); irq_ack[1] = 1'b0;
    repeat (8) run_cycle("pre_en2");
    en = 1'b0;
    repeat (3) run_cycle("en_low");
    irq_in[1] = 1'b1; run_cycle("en_low_pulse"); irq_in[1] = 1'b0;
    repeat (6) run_cycle("en_low");
    en = 1'b1;
    repeat (16) run_cycle("en_restart");

    // Mid-cycle reset at phase 3 of dut_a with irq_out set
    irq_in[0] = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      run_cycle("arst_wait");
      if (m_phase[0] == 3 && m_out[0][0]) found = 1'b1;
    end
    check("arst_setup", found, 1'b1);
    async_reset("arst_ph3", 2);
    repeat (16) run_cycle("arst_release");

    // Randomized run with occasional mid-cycle resets
    for (int i = 0; i < 2500; i++) begin
      drive_random();
      run_cycle("rand");
      if ($urandom_range(0, 299) == 0) async_reset("rand_arst", $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
